// File: rtl/gpio_ctrl_pkg.sv
// Register map shared by the GPIO controller and its integrators.
package gpio_ctrl_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  localparam logic [ADDR_W-1:0] ADDR_DATA_OUT = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_DATA_IN  = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_OUT_SET  = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// One pin: SYNC_STAGES-flop synchroniser, optional debounce (GPIO_DEBOUNCE_EN), edge detect.
// Edges appear SYNC_STAGES cycles after the pad (+DEB_CYCLES with debounce); no backpressure.
module gpio_sync_edge #(
  parameter int SYNC_STAGES = 2
`ifdef GPIO_DEBOUNCE_EN
  , parameter int DEB_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_in,
  output logic filt_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [CNT_W-1:0] deb_cnt;
  logic             filt_q;

  // Counter tracks consecutive cycles of disagreement; any agreement restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_cnt <= '0;
      filt_q  <= 1'b0;
    end else if (sync_in == filt_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CNT_W'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      filt_q  <= sync_in;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  assign filt_out = filt_q;
`else
  assign filt_out = sync_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= filt_out;
    end
  end

  assign rise = filt_out & ~prev_q;
  assign fall = ~filt_out & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO controller: direction, set/clear writes, sticky edge interrupts; GPIO_DEBOUNCE_EN adds input filter.
// Reads return one cycle after re, writes land at the clock edge; bus is always ready, no backpressure.
module gpio_ctrl
  import gpio_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  input  logic              re,
  output logic [31:0]       rdata,
  output logic              rvalid,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq
);

  if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEB_CYCLES < 1) begin : g_bad_params
    $error("gpio_ctrl: parameter out of range");
  end

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] wdata_w;
  logic [WIDTH-1:0] status_set;
  logic [WIDTH-1:0] status_clr;
  logic [WIDTH-1:0] rd_sel;
  logic [31:0]      rd_mux;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
`ifdef GPIO_DEBOUNCE_EN
      , .DEB_CYCLES(DEB_CYCLES)
`endif
    ) u_pin (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_in  (gpio_in[i]),
      .filt_out(data_in[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  assign wdata_w    = wdata[WIDTH-1:0];
  assign status_set = (rise & rise_en) | (fall & fall_en);
  assign status_clr = (we && addr == ADDR_STATUS) ? wdata_w : '0;

  always_comb begin
    rd_sel = '0;
    case (addr)
      ADDR_DATA_OUT: rd_sel = data_out;
      ADDR_DIR:      rd_sel = dir;
      ADDR_DATA_IN:  rd_sel = data_in;
      ADDR_RISE_EN:  rd_sel = rise_en;
      ADDR_FALL_EN:  rd_sel = fall_en;
      ADDR_STATUS:   rd_sel = status;
      default:       rd_sel = '0;
    endcase
    rd_mux              = '0;
    rd_mux[WIDTH-1:0]   = rd_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
    end else if (we) begin
      case (addr)
        ADDR_DATA_OUT: data_out <= wdata_w;
        ADDR_DIR:      dir      <= wdata_w;
        ADDR_RISE_EN:  rise_en  <= wdata_w;
        ADDR_FALL_EN:  fall_en  <= wdata_w;
        ADDR_OUT_SET:  data_out <= data_out | wdata_w;
        ADDR_OUT_CLR:  data_out <= data_out & ~wdata_w;
        default:       ;
      endcase
    end
  end

  // Hardware set is applied after the clear so a colliding edge is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
      irq    <= 1'b0;
    end else begin
      status <= (status & ~status_clr) | status_set;
      irq    <= |status;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= re;
      if (re) begin
        rdata <= rd_mux;
      end
    end
  end

  assign gpio_out = data_out;
  assign gpio_oe  = dir;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Bench for gpio_ctrl: behavioural register/edge model checked every cycle plus literal expectations.
module tb_gpio_ctrl;

  localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int DEB = 4;
  localparam int LAT = SYNC + DEB;
`else
  localparam int LAT = SYNC;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        we, re;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] gpio_in, gpio_out, gpio_oe;
  logic        irq;

  logic [2:0]  addr8;
  logic [31:0] wdata8;
  logic        we8, re8;
  logic [31:0] rdata8;
  logic        rvalid8;
  logic [7:0]  gpio_in8, gpio_out8, gpio_oe8;
  logic        irq8;

  always #5 clk = ~clk;

  gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(SYNC), .DEB_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .rvalid(rvalid), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .gpio_oe(gpio_oe), .irq(irq)
  );

  gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(SYNC), .DEB_CYCLES(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .addr(addr8), .wdata(wdata8), .we(we8), .re(re8),
    .rdata(rdata8), .rvalid(rvalid8), .gpio_in(gpio_in8), .gpio_out(gpio_out8),
    .gpio_oe(gpio_oe8), .irq(irq8)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_out, m_dir, m_re, m_fe, m_st, m_prev, m_rdata;
  logic        m_irq, m_rvalid;
  logic [31:0] m_samp [SYNC];
`ifdef GPIO_DEBOUNCE_EN
  logic [31:0] m_filt;
  int          m_cnt [32];
`endif

  function automatic logic [31:0] m_in();
`ifdef GPIO_DEBOUNCE_EN
    return m_filt;
`else
    return m_samp[SYNC-1];
`endif
  endfunction

  function automatic logic [31:0] mread(input logic [2:0] a, input logic [31:0] din);
    case (a)
      3'd0:    return m_out;
      3'd1:    return m_dir;
      3'd2:    return din;
      3'd3:    return m_re;
      3'd4:    return m_fe;
      3'd5:    return m_st;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] cur, set, clr;
`ifdef GPIO_DEBOUNCE_EN
    logic [31:0] s;
`endif
    if (!rst_n) begin
      m_out = 0; m_dir = 0; m_re = 0; m_fe = 0; m_st = 0; m_prev = 0;
      m_rdata = 0; m_irq = 0; m_rvalid = 0;
      for (int k = 0; k < SYNC; k++) m_samp[k] = 0;
`ifdef GPIO_DEBOUNCE_EN
      m_filt = 0;
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
`endif
    end else begin
      cur = m_in();
      set = (cur & ~m_prev & m_re) | (~cur & m_prev & m_fe);
      m_rvalid = re;
      if (re) m_rdata = mread(addr, cur);
      m_irq = |m_st;
      clr = (we && addr == 3'd5) ? wdata : 32'h0;
      m_st = (m_st & ~clr) | set;
      if (we) begin
        case (addr)
          3'd0: m_out = wdata;
          3'd1: m_dir = wdata;
          3'd3: m_re = wdata;
          3'd4: m_fe = wdata;
          3'd6: m_out = m_out | wdata;
          3'd7: m_out = m_out & ~wdata;
          default: ;
        endcase
      end
      m_prev = cur;
`ifdef GPIO_DEBOUNCE_EN
      s = m_samp[SYNC-1];
      for (int i = 0; i < 32; i++) begin
        if (s[i] == m_filt[i]) m_cnt[i] = 0;
        else if (m_cnt[i] + 1 == DEB) begin
          m_filt[i] = s[i];
          m_cnt[i] = 0;
        end else m_cnt[i] = m_cnt[i] + 1;
      end
`endif
      for (int k = SYNC - 1; k > 0; k--) m_samp[k] = m_samp[k-1];
      m_samp[0] = gpio_in;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("gpio_out", gpio_out, m_out);
    chk("gpio_oe", gpio_oe, m_dir);
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
    chk("rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
    if (m_rvalid) chk("rdata", rdata, m_rdata);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("rd_latency", {31'b0, rvalid}, 32'h1);
    d = rdata;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [31:0] d;
    rst_n = 1'b1; we = 0; re = 0; addr = 0; wdata = 0; gpio_in = 0;
    we8 = 0; re8 = 0; addr8 = 0; wdata8 = 0; gpio_in8 = 8'hA5;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_gpio_oe", gpio_oe, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst_n = 1'b1;

    // reset arriving mid-write
    wr(0, 32'hFFFF_0000);
    wr(1, 32'h0000_FFFF);
    addr = 0; wdata = 32'h1234_5678; we = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_gpio_out", gpio_out, 32'h0);
    chk("midrst_gpio_oe", gpio_oe, 32'h0);
    @(negedge clk); we = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    rd(0, d); chk("midrst_rd0", d, 32'h0);
    rd(1, d); chk("midrst_rd1", d, 32'h0);
    rd(5, d); chk("midrst_rd5", d, 32'h0);

    // outputs, set/clear
    wr(1, 32'h0000_00FF);
    wr(0, 32'hA5A5_A5A5);
    wr(6, 32'h0F00_0000);
    wr(7, 32'h0000_0005);
    chk("setclr_gpio_out", gpio_out, 32'hAFA5_A5A0);
    chk("setclr_gpio_oe", gpio_oe, 32'h0000_00FF);
    rd(0, d); chk("rd_data_out", d, 32'hAFA5_A5A0);
    rd(1, d); chk("rd_dir", d, 32'h0000_00FF);
    rd(6, d); chk("rd_out_set", d, 32'h0);
    rd(7, d); chk("rd_out_clr", d, 32'h0);

    // read and write together: read sees pre-write value
    addr = 0; wdata = 32'h11; we = 1'b1; re = 1'b1;
    @(negedge clk); we = 1'b0; re = 1'b0;
    chk("rw_same_old", rdata, 32'hAFA5_A5A0);
    rd(0, d); chk("rw_same_new", d, 32'h11);
    wr(2, 32'hFFFF_FFFF);
    rd(2, d); chk("data_in_ro", d, 32'h0);

    // rising edge interrupt latency
    wr(0, 32'h0);
    wr(3, 32'h1);
    gpio_in[0] = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      chk($sformatf("irq_lat_%0d", k), {31'b0, irq}, (k == LAT + 2) ? 32'h1 : 32'h0);
    end
    rd(5, d); chk("status_rise", d, 32'h1);
    wr(5, 32'h1);
    @(negedge clk);
    chk("irq_w1c", {31'b0, irq}, 32'h0);
    gpio_in[0] = 1'b0;
    tick(LAT + 4);
    rd(5, d); chk("status_no_fall", d, 32'h0);
    chk("irq_no_fall", {31'b0, irq}, 32'h0);

    // W1C colliding with a detected falling edge
    wr(3, 32'h0);
    wr(4, 32'h8);
    gpio_in[3] = 1'b1;
    tick(LAT + 4);
    gpio_in[3] = 1'b0;
    tick(LAT);
    addr = 5; wdata = 32'h8; we = 1'b1;
    @(negedge clk); we = 1'b0;
    rd(5, d); chk("collide_status", d, 32'h8);
    wr(5, 32'h8);
    tick(1);
    rd(5, d); chk("collide_cleared", d, 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      we    = ($urandom_range(2) == 0);
      re    = $urandom_range(1);
      addr  = 3'($urandom_range(7));
      wdata = $urandom;
      if ($urandom_range(3) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(31));
      @(negedge clk);
    end
    we = 1'b0; re = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 32'h0;
    wr(3, 32'h0);
    wr(4, 32'h0);
    tick(LAT + 6);
    wr(5, 32'hFFFF_FFFF);
    wr(3, 32'h4);
    gpio_in[2] = 1'b1;
    tick(3);
    gpio_in[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      rd(2, d); chk("deb_glitch_in", {31'b0, d[2]}, 32'h0);
    end
    rd(5, d); chk("deb_glitch_status", d, 32'h0);
    gpio_in[2] = 1'b1;
    tick(5);
    gpio_in[2] = 1'b0;
    tick(1);
    rd(2, d); chk("deb_pulse_in", d, 32'h4);
    tick(LAT + 4);
    rd(5, d); chk("deb_pulse_status", d, 32'h4);
`endif

    // narrow instance: bits above WIDTH
    addr8 = 0; wdata8 = 32'hFFFF_FFFF; we8 = 1'b1;
    @(negedge clk); we8 = 1'b0;
    chk("w8_gpio_out", {24'b0, gpio_out8}, 32'hFF);
    addr8 = 0; re8 = 1'b1;
    @(negedge clk); re8 = 1'b0;
    chk("w8_rd_data_out", rdata8, 32'h0000_00FF);
    addr8 = 2; re8 = 1'b1;
    @(negedge clk); re8 = 1'b0;
    chk("w8_rd_data_in", rdata8, 32'h0000_00A5);

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
Parametrised GPIO controller, next generation of the single-register GPIO block. Adds per-pin direction control, synchronised inputs, atomic set/clear writes, and per-pin rising/falling edge interrupts with a sticky status register. Sits on the core's memory-mapped peripheral bus; drives pad output and enable signals and raises one level interrupt to the interrupt controller.

Parameters:
WIDTH, 32, number of GPIO pins (1..32); register bits above WIDTH read 0, writes ignored
SYNC_STAGES, 2, flip-flop stages on gpio_in before any use (2..4)
DEB_CYCLES, 4, stable-cycle count for the debounce filter (used only with GPIO_DEBOUNCE_EN; >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
addr  input  3  register word index
wdata  input  32  write data
we  input  1  write enable, one write per cycle
re  input  1  read enable
rdata  output  32  read data, valid when rvalid=1
rvalid  output  1  read response strobe
gpio_in  input  WIDTH  asynchronous pad inputs
gpio_out  output  WIDTH  pad output values
gpio_oe  output  WIDTH  pad output enables (1 = drive)
irq  output  1  level interrupt, registered

Behaviour:
- Reset (async assert of rst_n low, sync release is the integrator's job): DATA_OUT, DIR, RISE_EN, FALL_EN, STATUS, synchroniser, edge-history regs = 0; gpio_out=0, gpio_oe=0, irq=0, rdata=0, rvalid=0. Reset mid-transaction aborts it; no response is issued.
- Register map (addr): 0 DATA_OUT RW; 1 DIR RW (1=output); 2 DATA_IN RO, synchronised value; 3 RISE_EN RW; 4 FALL_EN RW; 5 STATUS RO / write-1-to-clear; 6 OUT_SET WO (DATA_OUT |= wdata); 7 OUT_CLR WO (DATA_OUT &= ~wdata). Reads of 6/7 return 0. Writes to 2 are ignored.
- Writes take effect at the clock edge where we=1; gpio_out/gpio_oe reflect the new value on the following cycle (direct register outputs).
- Reads: rvalid and rdata registered, 1-cycle latency after re=1; back-to-back reads supported every cycle. we and re in the same cycle: the write commits, and the read returns the pre-write value.
- gpio_out = DATA_OUT; gpio_oe = DIR. Inputs are sampled regardless of DIR, so loopback reads of output pins work.
- Input path: gpio_in passes through SYNC_STAGES flops to produce sync_in; prev_in holds sync_in delayed by one cycle. rise = sync_in & ~prev_in; fall = ~sync_in & prev_in.
- STATUS[i] sets on (rise[i]&RISE_EN[i]) | (fall[i]&FALL_EN[i]). A W1C write to bit i clears it. A set and a clear of the same bit in the same cycle leaves the bit set (hardware set wins).
- irq is the registered value of |STATUS, so it goes high one cycle after the STATUS bit sets. Latency from a gpio_in edge to irq is SYNC_STAGES+2 cycles.
- Disabling an enable does not clear pending STATUS bits.

Optional Feature:
GPIO_DEBOUNCE_EN:
- Defined: a per-pin filter sits between the synchroniser and edge detection. The filtered value updates only after sync_in has differed from it for DEB_CYCLES consecutive cycles. Each pin has its own counter, width $clog2(DEB_CYCLES+1); the counter clears whenever sync_in equals the filtered value. Counters reset to 0 and filtered values reset to 0. DATA_IN returns the filtered value, and edge latency grows by DEB_CYCLES.
- Undefined: no filter; filtered value = sync_in.

Decomposition:
- Package gpio_ctrl_pkg holds register address localparams (ADDR_DATA_OUT..ADDR_OUT_CLR) and the register count.
- One sub-module, gpio_sync_edge: the per-pin synchroniser, optional debounce and edge detector, instantiated WIDTH times via generate.

Test Plan:
- Reset: rst_n=0 mid-write -> all outputs 0, read addr 0/1/5 returns 0 after release.
- DIR=0x0000_00FF, DATA_OUT=0xA5A5_A5A5, then OUT_SET 0x0F00_0000, OUT_CLR 0x0000_0005 -> gpio_out=0xAFA5_A5A0, gpio_oe=0xFF, read latency exactly 1 cycle.
- RISE_EN=0x1, gpio_in[0] 0->1 -> STATUS=0x1 and irq=1 exactly 4 cycles later (SYNC_STAGES=2); falling edge sets nothing; W1C 0x1 -> irq=0 next cycle.
- Set and clear collide: W1C of bit 3 in the same cycle a falling edge on pin 3 is detected with FALL_EN[3]=1 -> STATUS[3] stays 1.
- WIDTH=8: write 0xFFFF_FFFF to DATA_OUT -> readback 0x0000_00FF; DATA_IN upper bits read 0.
- GPIO_DEBOUNCE_EN, DEB_CYCLES=4: 3-cycle glitch on gpio_in[2] -> no DATA_IN change, no STATUS; 5-cycle pulse -> DATA_IN[2]=1 and rise captured.
